// File: rtl/ps2_cmd_sched_if.sv
// Requester, transceiver and scan-code bus bundle for ps2_cmd_sched.
interface ps2_cmd_sched_if;
    logic [2:0]  req_valid;
    logic [23:0] req_cmd;
    logic [2:0]  req_has_arg;
    logic [23:0] req_arg;
    logic [2:0]  req_grant;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [1:0]  rsp_status;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic        tx_done;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        scan_valid;
    logic [7:0]  scan_byte;
    logic        busy;

    // Scheduler side: drives grants, responses, transmit and scan outputs.
    modport master (
        input  req_valid, req_cmd, req_has_arg, req_arg,
        input  tx_busy, tx_done, rx_valid, rx_byte,
        output req_grant, rsp_valid, rsp_id, rsp_status,
        output tx_start, tx_byte, scan_valid, scan_byte, busy
    );

    // Environment side: requesters, transceiver and scan-code decoder.
    modport slave (
        output req_valid, req_cmd, req_has_arg, req_arg,
        output tx_busy, tx_done, rx_valid, rx_byte,
        input  req_grant, rsp_valid, rsp_id, rsp_status,
        input  tx_start, tx_byte, scan_valid, scan_byte, busy
    );
endinterface

// File: rtl/ps2_cmd_sched.sv
// PS/2 host-command scheduler: round-robin grant, command/argument send,
// ACK/resend/timeout handling and forwarding of non-protocol receive bytes.
module ps2_cmd_sched #(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TMR_W       = 20
) (
    input  logic           clk,
    input  logic           rst,
    ps2_cmd_sched_if.master bus
);

    localparam logic [7:0]       BYTE_ACK    = 8'hFA;
    localparam logic [7:0]       BYTE_RESEND = 8'hFE;
    localparam logic [1:0]       ST_OK       = 2'b00;
    localparam logic [1:0]       ST_RETRY    = 2'b01;
    localparam logic [1:0]       ST_TMO      = 2'b10;
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_CMD = 3'd1,
        WAIT_CMD = 3'd2,
        SEND_ARG = 3'd3,
        WAIT_ARG = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [1:0]       retry_cnt;
    logic [1:0]       cur_id;
    logic [7:0]       cur_cmd;
    logic [7:0]       cur_arg;
    logic             cur_has_arg;
    logic             sent;
    logic [TMR_W-1:0] timer;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       next_ptr;
    logic [2:0]       cand;
    logic             in_wait;
    logic             rx_ack;
    logic             rx_resend;
    logic             fwd;
    logic             rsp_fire;
    logic [1:0]       rsp_code;

    // Round-robin search starting at rr_ptr; the lowest offset with a request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (bus.req_valid[cand[1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[1:0];
            end
        end
        next_ptr = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end

    // Protocol byte decode and end-of-transaction decision while waiting.
    always_comb begin
        in_wait   = (state == WAIT_CMD) || (state == WAIT_ARG);
        rx_ack    = bus.rx_valid && (bus.rx_byte == BYTE_ACK);
        rx_resend = bus.rx_valid && (bus.rx_byte == BYTE_RESEND);
        fwd       = bus.rx_valid && !(in_wait && (rx_ack || rx_resend));
        rsp_fire  = 1'b0;
        rsp_code  = ST_OK;
        if (in_wait) begin
            if (rx_ack) begin
                rsp_fire = !((state == WAIT_CMD) && cur_has_arg);
            end else if (rx_resend) begin
                if (retry_cnt >= RETRY_MAX) begin
                    rsp_fire = 1'b1;
                    rsp_code = ST_RETRY;
                end
            end else if (timer == TMR_LAST) begin
                rsp_fire = 1'b1;
                rsp_code = ST_TMO;
            end
        end
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= 2'd0;
            retry_cnt      <= 2'd0;
            cur_id         <= 2'd0;
            cur_cmd        <= 8'd0;
            cur_arg        <= 8'd0;
            cur_has_arg    <= 1'b0;
            sent           <= 1'b0;
            timer          <= '0;
            bus.req_grant  <= 3'd0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 2'd0;
            bus.rsp_status <= 2'd0;
            bus.tx_start   <= 1'b0;
            bus.tx_byte    <= 8'd0;
            bus.scan_valid <= 1'b0;
            bus.scan_byte  <= 8'd0;
            bus.busy       <= 1'b0;
        end else begin
            bus.req_grant  <= 3'd0;
            bus.rsp_valid  <= 1'b0;
            bus.tx_start   <= 1'b0;
            bus.scan_valid <= fwd;
            if (fwd) begin
                bus.scan_byte <= bus.rx_byte;
            end

            case (state)
                IDLE: begin
                    if (win_found) begin
                        bus.req_grant <= 3'b001 << win_idx;
                        cur_id        <= win_idx;
                        cur_cmd       <= bus.req_cmd[{win_idx, 3'b000} +: 8];
                        cur_arg       <= bus.req_arg[{win_idx, 3'b000} +: 8];
                        cur_has_arg   <= bus.req_has_arg[win_idx];
                        rr_ptr        <= next_ptr;
                        retry_cnt     <= 2'd0;
                        sent          <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= SEND_CMD;
                    end
                end
                SEND_CMD, SEND_ARG: begin
                    if (!sent) begin
                        if (!bus.tx_busy) begin
                            bus.tx_start <= 1'b1;
                            bus.tx_byte  <= (state == SEND_CMD) ? cur_cmd : cur_arg;
                            sent         <= 1'b1;
                        end
                    end else if (bus.tx_done) begin
                        sent  <= 1'b0;
                        timer <= '0;
                        state <= (state == SEND_CMD) ? WAIT_CMD : WAIT_ARG;
                    end
                end
                WAIT_CMD, WAIT_ARG: begin
                    if (rsp_fire) begin
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_id     <= cur_id;
                        bus.rsp_status <= rsp_code;
                        state          <= RESP;
                    end else if (rx_ack) begin
                        retry_cnt <= 2'd0;
                        state     <= SEND_ARG;
                    end else if (rx_resend) begin
                        retry_cnt <= retry_cnt + 2'd1;
                        state     <= (state == WAIT_CMD) ? SEND_CMD : SEND_ARG;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Self-checking bench for ps2_cmd_sched with a transceiver/keyboard model.
`timescale 1ns/1ps
module tb_ps2_cmd_sched;

    localparam int TMO  = 50;
    localparam int MAXR = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_cmd_sched_if bus();

    ps2_cmd_sched #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .TMR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int nc    = 0;

    // transceiver / keyboard model
    logic [7:0] plan_q[$];
    int         rsp_dly;
    logic [7:0] noise_byte;
    int         xcv_left;
    int         resp_at;
    logic [7:0] resp_byte;
    int         noise_at;
    int         inj_at;
    logic [7:0] inj_byte;
    logic       auto_drop;

    // observation logs
    logic [7:0] tx_log[$];
    int         grant_log[$];
    int         done_log[$];
    logic [7:0] scan_log[$];
    int         rsp_n;
    logic [1:0] rsp_id_l;
    logic [1:0] rsp_st_l;
    int         rsp_at_l;
    logic       rsp_busy_l;
    int         grant_at;
    int         first_tx_at;
    int         txbusy_viol;
    logic       last_busy;

    typedef struct packed {
        logic [1:0]      rid;
        logic [7:0]      cmd;
        logic            has_arg;
        logic [7:0]      arg;
        logic [5:0][7:0] plan;      // device answer per attempt, 00 = silent
        logic [7:0]      dly;       // answer delay after tx_done
        logic [7:0]      noise;     // scan byte 20 cycles after tx_done, 00 = none
        logic [3:0]      exp_ntx;
        logic [3:0]      exp_ncmd;
        logic [1:0]      exp_st;
        logic [3:0]      exp_nscan;
        logic [7:0]      exp_scan0;
        logic [7:0]      exp_rspd;  // cycles from last tx_done to rsp_valid
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, nc);
        end
    endtask

    task automatic clear_logs();
        tx_log.delete();
        grant_log.delete();
        done_log.delete();
        scan_log.delete();
        rsp_n       = 0;
        grant_at    = -1;
        first_tx_at = -1;
        txbusy_viol = 0;
    endtask

    task automatic dev_reset();
        plan_q.delete();
        xcv_left       = 0;
        resp_at        = -1;
        noise_at       = -1;
        inj_at         = -1;
        inj_byte       = 8'h00;
        resp_byte      = 8'h00;
        noise_byte     = 8'h00;
        rsp_dly        = 10;
        bus.tx_busy    = 1'b0;
        bus.tx_done    = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_byte    = 8'h00;
    endtask

    // One clock: observe DUT outputs at the falling edge, then drive the model.
    task automatic step();
        logic [7:0] r;
        @(negedge clk);
        nc++;
        last_busy = bus.busy;
        if (bus.tx_start) begin
            if (bus.tx_busy) txbusy_viol++;
            tx_log.push_back(bus.tx_byte);
            if (tx_log.size() == 1) first_tx_at = nc;
        end
        if (bus.req_grant != 3'b000) begin
            for (int i = 0; i < 3; i++) if (bus.req_grant[i]) grant_log.push_back(i);
            grant_at = nc;
            if (auto_drop) begin
                bus.req_valid   = 3'b000;
                bus.req_cmd     = 24'($urandom);
                bus.req_arg     = 24'($urandom);
                bus.req_has_arg = 3'($urandom);
            end
        end
        if (bus.scan_valid) scan_log.push_back(bus.scan_byte);
        if (bus.rsp_valid) begin
            rsp_n++;
            rsp_id_l   = bus.rsp_id;
            rsp_st_l   = bus.rsp_status;
            rsp_at_l   = nc;
            rsp_busy_l = bus.busy;
        end
        bus.tx_done  = 1'b0;
        bus.rx_valid = 1'b0;
        if (bus.tx_start) begin
            bus.tx_busy = 1'b1;
            xcv_left    = 4;
        end else if (xcv_left > 0) begin
            xcv_left--;
            if (xcv_left == 0) begin
                bus.tx_busy = 1'b0;
                bus.tx_done = 1'b1;
                done_log.push_back(nc);
                r = (plan_q.size() > 0) ? plan_q.pop_front() : 8'h00;
                if (r != 8'h00) begin
                    resp_at   = nc + rsp_dly;
                    resp_byte = r;
                end
                if (noise_byte != 8'h00) noise_at = nc + 20;
            end
        end
        if (nc == resp_at) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = resp_byte;
        end else if (nc == noise_at) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = noise_byte;
        end else if (nc == inj_at) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = inj_byte;
        end
    endtask

    task automatic wait_rsp(input int want, input int limit, input string name);
        int cnt;
        cnt = 0;
        while (rsp_n < want && cnt < limit) begin
            step();
            cnt++;
        end
        check(name, 32'(rsp_n), 32'(want));
    endtask

    // Expected outcome of one transaction, from the protocol rules alone.
    function automatic void ref_txn(input logic has_arg, input logic [7:0] cmd, input logic [7:0] arg,
                                    input logic [7:0] plan [8], output logic [7:0] bytes [8],
                                    output int n, output logic [1:0] st);
        int fails;
        bit on_arg;
        fails  = 0;
        on_arg = 1'b0;
        n      = 0;
        st     = 2'b10;
        for (int i = 0; i < 8; i++) bytes[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bytes[n] = on_arg ? arg : cmd;
            n++;
            if (plan[i] == 8'hFA) begin
                if (!on_arg && has_arg) begin
                    on_arg = 1'b1;
                    fails  = 0;
                end else begin
                    st = 2'b00;
                    return;
                end
            end else if (plan[i] == 8'hFE) begin
                fails++;
                if (fails > MAXR) begin
                    st = 2'b01;
                    return;
                end
            end else begin
                st = 2'b10;
                return;
            end
        end
    endfunction

    function automatic vec_t mkv(input logic [1:0] rid, input logic [7:0] cmd, input logic ha,
                                 input logic [7:0] arg, input logic [7:0] p0, input logic [7:0] p1,
                                 input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] p4,
                                 input logic [7:0] p5, input logic [7:0] dly, input logic [7:0] noise,
                                 input logic [3:0] ntx, input logic [3:0] ncmd, input logic [1:0] st,
                                 input logic [3:0] nscan, input logic [7:0] scan0, input logic [7:0] rspd);
        vec_t v;
        v.rid = rid; v.cmd = cmd; v.has_arg = ha; v.arg = arg;
        v.plan[0] = p0; v.plan[1] = p1; v.plan[2] = p2;
        v.plan[3] = p3; v.plan[4] = p4; v.plan[5] = p5;
        v.dly = dly; v.noise = noise;
        v.exp_ntx = ntx; v.exp_ncmd = ncmd; v.exp_st = st;
        v.exp_nscan = nscan; v.exp_scan0 = scan0; v.exp_rspd = rspd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] eb;
        clear_logs();
        plan_q.delete();
        for (int i = 0; i < 6; i++) plan_q.push_back(v.plan[i]);
        rsp_dly    = int'(v.dly);
        noise_byte = v.noise;
        resp_at    = -1;
        noise_at   = -1;
        bus.req_cmd     = 24'($urandom);
        bus.req_arg     = 24'($urandom);
        bus.req_has_arg = 3'($urandom);
        bus.req_cmd[{v.rid, 3'b000} +: 8] = v.cmd;
        bus.req_arg[{v.rid, 3'b000} +: 8] = v.arg;
        bus.req_has_arg[v.rid]             = v.has_arg;
        bus.req_valid = 3'b001 << v.rid;
        wait_rsp(1, 1500, $sformatf("v%0d_rsp_count", idx));
        repeat (6) step();
        check($sformatf("v%0d_grant_count", idx), 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) check($sformatf("v%0d_grant_id", idx), 32'(grant_log[0]), 32'(v.rid));
        check($sformatf("v%0d_first_tx_latency", idx), 32'(first_tx_at - grant_at), 32'd1);
        check($sformatf("v%0d_tx_count", idx), 32'(tx_log.size()), 32'(v.exp_ntx));
        for (int i = 0; i < int'(v.exp_ntx); i++) begin
            eb = (i < int'(v.exp_ncmd)) ? v.cmd : v.arg;
            check($sformatf("v%0d_tx_byte%0d", idx, i),
                  (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD_BEEF, 32'(eb));
        end
        check($sformatf("v%0d_rsp_id", idx), 32'(rsp_id_l), 32'(v.rid));
        check($sformatf("v%0d_rsp_status", idx), 32'(rsp_st_l), 32'(v.exp_st));
        check($sformatf("v%0d_rsp_busy", idx), 32'(rsp_busy_l), 32'd1);
        if (done_log.size() > 0)
            check($sformatf("v%0d_rsp_timing", idx), 32'(rsp_at_l - done_log[done_log.size()-1]),
                  32'(v.exp_rspd));
        check($sformatf("v%0d_scan_count", idx), 32'(scan_log.size()), 32'(v.exp_nscan));
        if (scan_log.size() > 0) check($sformatf("v%0d_scan_byte", idx), 32'(scan_log[0]), 32'(v.exp_scan0));
        check($sformatf("v%0d_tx_while_busy", idx), 32'(txbusy_viol), 32'd0);
        check($sformatf("v%0d_busy_after", idx), 32'(last_busy), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        auto_drop       = 1'b1;
        bus.req_valid   = 3'b000;
        bus.req_cmd     = 24'h0;
        bus.req_arg     = 24'h0;
        bus.req_has_arg = 3'b000;
        dev_reset();
        clear_logs();
        last_busy = 1'b0;
        rsp_id_l = 2'd0; rsp_st_l = 2'd0; rsp_at_l = 0; rsp_busy_l = 1'b0;

        //           rid   cmd    ha  arg    plan0  plan1  plan2  plan3  plan4  plan5  dly  noise  ntx ncmd st     nsc  scan0  rspd
        vt[0] = mkv(2'd0, 8'hEE, 0, 8'h00, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 30, 8'h00, 1,  1,  2'b00, 0, 8'h00, 31);
        vt[1] = mkv(2'd1, 8'hED, 1, 8'h02, 8'hFA, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 12, 8'h00, 2,  1,  2'b00, 0, 8'h00, 13);
        vt[2] = mkv(2'd2, 8'hF3, 0, 8'h00, 8'hFE, 8'hFE, 8'hFA, 8'h00, 8'h00, 8'h00,  7, 8'h00, 3,  3,  2'b00, 0, 8'h00,  8);
        vt[3] = mkv(2'd0, 8'hF4, 0, 8'h00, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'h00,  9, 8'h00, 4,  4,  2'b01, 0, 8'h00, 10);
        vt[4] = mkv(2'd1, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 30, 8'h1C, 1,  1,  2'b10, 1, 8'h1C, 51);
        vt[5] = mkv(2'd2, 8'hED, 1, 8'h07, 8'hFE, 8'hFA, 8'hFE, 8'hFE, 8'hFE, 8'hFE,  3, 8'h00, 6,  2,  2'b01, 0, 8'h00,  4);
        vt[6] = mkv(2'd0, 8'hF0, 1, 8'h03, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,  5, 8'h00, 2,  1,  2'b10, 0, 8'h00, 51);
        vt[7] = mkv(2'd1, 8'hF2, 0, 8'h00, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 50, 8'h00, 1,  1,  2'b00, 0, 8'h00, 51);
        vt[8] = mkv(2'd2, 8'hF2, 0, 8'h00, 8'hFA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 51, 8'h00, 1,  1,  2'b10, 1, 8'hFA, 51);
        vt[9] = mkv(2'd0, 8'hF5, 0, 8'h00, 8'hFE, 8'hFE, 8'hFE, 8'hFA, 8'h00, 8'h00,  4, 8'h00, 4,  4,  2'b00, 0, 8'h00,  5);

        // reset values
        step();
        step();
        check("reset_outputs",
              {11'd0, bus.req_grant, bus.rsp_valid, bus.rsp_id, bus.rsp_status, bus.tx_start,
               bus.tx_byte, bus.scan_valid, bus.scan_byte[7:0] == 8'h00},
              {11'd0, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1});
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step();

        // directed table
        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // reset while waiting for the argument ACK
        clear_logs();
        dev_reset();
        plan_q.push_back(8'hFA);
        plan_q.push_back(8'h00);
        rsp_dly = 5;
        bus.req_cmd = 24'h00ED00;
        bus.req_arg = 24'h000500;
        bus.req_has_arg = 3'b010;
        bus.req_valid = 3'b010;
        for (int c = 0; c < 200 && done_log.size() < 2; c++) step();
        check("rstw_arg_sent", 32'(done_log.size()), 32'd2);
        repeat (3) step();
        check("rstw_busy_before", 32'(last_busy), 32'd1);
        rst = 1'b1;
        step();
        check("rstw_busy_in_reset", 32'(last_busy), 32'd0);
        rst = 1'b0;
        dev_reset();
        clear_logs();
        repeat (80) step();
        check("rstw_no_rsp", 32'(rsp_n), 32'd0);
        check("rstw_no_tx", 32'(tx_log.size()), 32'd0);

        // contention: all three held, fresh pointer after reset
        auto_drop = 1'b0;
        rsp_dly = 5;
        for (int i = 0; i < 4; i++) plan_q.push_back(8'hFA);
        bus.req_cmd = 24'hF4F3ED;
        bus.req_has_arg = 3'b000;
        bus.req_valid = 3'b111;
        for (int c = 0; c < 1000 && grant_log.size() < 4; c++) step();
        bus.req_valid = 3'b000;
        wait_rsp(4, 400, "rr_rsp_count");
        repeat (4) step();
        auto_drop = 1'b1;
        check("rr_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hDEAD_BEEF,
                  32'(i % 3));
        check("rr_tx_count", 32'(tx_log.size()), 32'd4);

        // protocol bytes while idle are forwarded
        clear_logs();
        inj_byte = 8'hFA; inj_at = nc + 1;
        repeat (2) step();
        inj_byte = 8'hFE; inj_at = nc + 1;
        repeat (3) step();
        check("idle_scan_count", 32'(scan_log.size()), 32'd2);
        if (scan_log.size() == 2) begin
            check("idle_scan_fa", 32'(scan_log[0]), 32'h0000_00FA);
            check("idle_scan_fe", 32'(scan_log[1]), 32'h0000_00FE);
        end
        check("idle_no_grant", 32'(grant_log.size()), 32'd0);

        // randomized transactions against the reference model
        rst = 1'b1;
        step();
        rst = 1'b0;
        dev_reset();
        step();
        begin
            int mrr;
            mrr = 0;
            for (int t = 0; t < 25; t++) begin
                logic [2:0] mask;
                logic [7:0] plan_r [8];
                logic [7:0] eb [8];
                int         en;
                int         win;
                int         rr;
                logic [1:0] est;
                mask = 3'($urandom_range(7, 1));
                bus.req_cmd     = 24'($urandom);
                bus.req_arg     = 24'($urandom);
                bus.req_has_arg = 3'($urandom);
                win = -1;
                for (int k = 0; k < 3; k++)
                    if (win < 0 && mask[(mrr + k) % 3]) win = (mrr + k) % 3;
                for (int i = 0; i < 8; i++) begin
                    rr = $urandom_range(19, 0);
                    plan_r[i] = (rr < 10) ? 8'hFA : (rr < 17) ? 8'hFE : 8'h00;
                end
                ref_txn(bus.req_has_arg[win], bus.req_cmd[8*win +: 8], bus.req_arg[8*win +: 8],
                        plan_r, eb, en, est);
                clear_logs();
                plan_q.delete();
                for (int i = 0; i < 8; i++) plan_q.push_back(plan_r[i]);
                rsp_dly = $urandom_range(45, 1);
                noise_byte = 8'h00;
                resp_at = -1;
                noise_at = -1;
                bus.req_valid = mask;
                wait_rsp(1, 1500, $sformatf("r%0d_rsp_count", t));
                repeat (3) step();
                check($sformatf("r%0d_grant_count", t), 32'(grant_log.size()), 32'd1);
                if (grant_log.size() > 0) check($sformatf("r%0d_grant_id", t), 32'(grant_log[0]), 32'(win));
                check($sformatf("r%0d_tx_count", t), 32'(tx_log.size()), 32'(en));
                for (int i = 0; i < en; i++)
                    check($sformatf("r%0d_tx_byte%0d", t, i),
                          (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD_BEEF, 32'(eb[i]));
                check($sformatf("r%0d_rsp_status", t), 32'(rsp_st_l), 32'(est));
                check($sformatf("r%0d_rsp_id", t), 32'(rsp_id_l), 32'(win));
                check($sformatf("r%0d_tx_while_busy", t), 32'(txbusy_viol), 32'd0);
                mrr = (win + 1) % 3;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
